// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch resolution and the EX/MEM pipeline register.
// Define EX_MUL_EN to add the iterative shift-add multiplier (ALUControlE = 100) with a stall request.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        BusyE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [31:0] w_src_a, w_write_data, w_src_b, w_diff, w_alu_result, w_ex_result;
  logic        w_zero;
  logic        w_unused;

  // Hazard unit consumes the source indices; they only pass through here.
  assign w_unused = ^{Rs1E, Rs2E};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_src_a      = RD1E;
    w_write_data = RD2E;
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = ALUResultM;
      default: w_src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   w_write_data = ResultW;
      2'b10:   w_write_data = ALUResultM;
      default: w_write_data = RD2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ImmExtE : w_write_data;
  assign w_diff  = w_src_a - w_src_b;
  assign w_zero  = (w_diff == 32'd0);

  always_comb begin
    w_alu_result = 32'd0;
    case (ALUControlE)
      ALU_ADD: w_alu_result = w_src_a + w_src_b;
      ALU_SUB: w_alu_result = w_diff;
      ALU_AND: w_alu_result = w_src_a & w_src_b;
      ALU_OR:  w_alu_result = w_src_a | w_src_b;
      ALU_SLT: w_alu_result = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
      default: w_alu_result = 32'd0;
    endcase
  end

  assign PCSrcE    = JumpE | (BranchE & w_zero);
  assign PCTargetE = PCPlus4E - 32'd4 + ImmExtE;

`ifdef EX_MUL_EN
  localparam logic [2:0] ALU_MUL = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} mul_state_t;

  mul_state_t  r_state, w_next_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_mul_a, r_mul_b, r_acc;
  logic        w_issue;

  assign w_issue = (r_state == S_IDLE) && (ALUControlE == ALU_MUL);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next_state = S_MUL;
      S_MUL:   if (r_cnt == 5'd31) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    BusyE = w_issue || (r_state == S_MUL);
  end

  // Operands are captured at issue: forwarded sources keep moving while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 5'd0;
      r_acc   <= 32'd0;
      r_mul_a <= 32'd0;
      r_mul_b <= 32'd0;
    end else if (w_issue) begin
      r_cnt   <= 5'd0;
      r_acc   <= 32'd0;
      r_mul_a <= w_src_a;
      r_mul_b <= w_src_b;
    end else if (r_state == S_MUL) begin
      r_acc   <= r_acc + (r_mul_b[0] ? r_mul_a : 32'd0);
      r_mul_a <= r_mul_a << 1;
      r_mul_b <= r_mul_b >> 1;
      r_cnt   <= r_cnt + 5'd1;
    end
  end

  assign w_ex_result = (r_state == S_DONE) ? r_acc : w_alu_result;
`else
  assign BusyE       = 1'b0;
  assign w_ex_result = w_alu_result;
`endif

  // A stall loads a bubble; clearing every field keeps the bubble fully defined.
  always_ff @(posedge clk) begin
    if (reset || BusyE) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'd0;
      ALUResultM <= 32'd0;
      WriteDataM <= 32'd0;
      PCPlus4M   <= 32'd0;
      RdM        <= 5'd0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= w_ex_result;
      WriteDataM <= w_write_data;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage; multiplier vectors are built only when EX_MUL_EN is defined.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE, BusyE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;

  int checks = 0;
  int failures = 0;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] rd, input logic rw);
    ALUControlE = ctl; RD1E = a; RD2E = b; RdE = rd; RegWriteE = rw;
    ALUSrcE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    BranchE = 1'b0; JumpE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 2'b00;
  endtask

  initial begin
    // Reset with every input driven nonzero.
    reset = 1'b1;
    RegWriteE = 1'b1; MemWriteE = 1'b1; JumpE = 1'b1; BranchE = 1'b1; ALUSrcE = 1'b1;
    ResultSrcE = 2'b11; ALUControlE = 3'b000; RD1E = 32'h1111; RD2E = 32'h2222;
    ImmExtE = 32'h33; PCPlus4E = 32'h44; Rs1E = 5'd1; Rs2E = 5'd2; RdE = 5'd7;
    ForwardAE = 2'b01; ForwardBE = 2'b10; ResultW = 32'h55;
    tick(); tick();
    check("rst_regwrite", {31'd0, RegWriteM}, 32'd0);
    check("rst_memwrite", {31'd0, MemWriteM}, 32'd0);
    check("rst_resultsrc", {30'd0, ResultSrcM}, 32'd0);
    check("rst_aluresult", ALUResultM, 32'd0);
    check("rst_writedata", WriteDataM, 32'd0);
    check("rst_pcplus4", PCPlus4M, 32'd0);
    check("rst_rd", {27'd0, RdM}, 32'd0);
    check("rst_busy", {31'd0, BusyE}, 32'd0);
    reset = 1'b0;

    op(3'b000, 32'd5, 32'd7, 5'd3, 1'b1);
    PCPlus4E = 32'h200; ResultSrcE = 2'b10; MemWriteE = 1'b1;
    #1 check("add_busy", {31'd0, BusyE}, 32'd0);
    tick();
    check("add_result", ALUResultM, 32'd12);
    check("add_rd", {27'd0, RdM}, 32'd3);
    check("add_regwrite", {31'd0, RegWriteM}, 32'd1);
    check("add_writedata", WriteDataM, 32'd7);
    check("add_pcplus4", PCPlus4M, 32'h200);
    check("add_resultsrc", {30'd0, ResultSrcM}, 32'd2);
    check("add_memwrite", {31'd0, MemWriteM}, 32'd1);

    // A from ALUResultM (12), B/WriteData from ResultW (3).
    op(3'b000, 32'hDEAD, 32'hBEEF, 5'd4, 1'b1);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd3;
    tick();
    check("fwd_result", ALUResultM, 32'd15);
    check("fwd_writedata", WriteDataM, 32'd3);

    op(3'b000, 32'd10, 32'd20, 5'd4, 1'b1);
    ForwardAE = 2'b11; ForwardBE = 2'b11;
    tick();
    check("fwd11_result", ALUResultM, 32'd30);

    op(3'b001, 32'd5, 32'd7, 5'd5, 1'b1);
    tick();
    check("sub_result", ALUResultM, 32'hFFFF_FFFE);

    op(3'b101, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1);
    tick();
    check("slt_neg_lt_pos", ALUResultM, 32'd1);

    op(3'b101, 32'd1, 32'hFFFF_FFFF, 5'd6, 1'b1);
    tick();
    check("slt_pos_lt_neg", ALUResultM, 32'd0);

    op(3'b010, 32'h0000_F0F0, 32'h0000_FF00, 5'd7, 1'b1);
    tick();
    check("and_result", ALUResultM, 32'h0000_F000);

    op(3'b011, 32'h0000_F0F0, 32'h0000_FF00, 5'd7, 1'b1);
    tick();
    check("or_result", ALUResultM, 32'h0000_FFF0);

    op(3'b000, 32'd100, 32'd999, 5'd8, 1'b1);
    ALUSrcE = 1'b1; ImmExtE = 32'hFFFF_FFFC;
    tick();
    check("addi_result", ALUResultM, 32'd96);
    check("addi_writedata", WriteDataM, 32'd999);

    op(3'b110, 32'd3, 32'd4, 5'd9, 1'b1);
    tick();
    check("undef110_result", ALUResultM, 32'd0);

    // beq: target = 0x104 - 4 - 8.
    op(3'b001, 32'd9, 32'd9, 5'd0, 1'b0);
    BranchE = 1'b1; PCPlus4E = 32'h104; ImmExtE = 32'hFFFF_FFF8;
    #1;
    check("beq_taken", {31'd0, PCSrcE}, 32'd1);
    check("beq_target", PCTargetE, 32'h0000_00F8);
    RD2E = 32'd8;
    #1 check("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    JumpE = 1'b1; BranchE = 1'b0;
    #1 check("jal_taken", {31'd0, PCSrcE}, 32'd1);
    // Zero flag comes from the subtractor regardless of the ALU op.
    JumpE = 1'b0; BranchE = 1'b1; ALUControlE = 3'b011; RD2E = 32'd9;
    #1 check("beq_zero_any_op", {31'd0, PCSrcE}, 32'd1);
    tick();

`ifdef EX_MUL_EN
    begin
      int busy_cycles;
      int bad_writes;
      op(3'b000, 32'd1, 32'd1, 5'd2, 1'b1);
      tick();
      op(3'b100, 32'h0001_0000, 32'hAAAA_AAAA, 5'd5, 1'b1);
      ForwardBE = 2'b01; ResultW = 32'h0001_0003;
      #1;
      busy_cycles = 0; bad_writes = 0;
      while (BusyE && busy_cycles < 40) begin
        busy_cycles++;
        tick();
        if (RegWriteM !== 1'b0) bad_writes++;
        ResultW = ResultW ^ 32'h5A5A_5A5A;
        #1;
      end
      check("mul_busy_cycles", busy_cycles, 32'd33);
      check("mul_stall_writes", bad_writes, 32'd0);
      check("mul_done_busy", {31'd0, BusyE}, 32'd0);
      tick();
      check("mul_product", ALUResultM, 32'h0003_0000);
      check("mul_rd", {27'd0, RdM}, 32'd5);
      check("mul_regwrite", {31'd0, RegWriteM}, 32'd1);

      // Abort after issue + 10 MUL steps.
      op(3'b100, 32'd7, 32'd9, 5'd10, 1'b1);
      for (int i = 0; i < 11; i++) tick();
      check("abort_busy_before", {31'd0, BusyE}, 32'd1);
      reset = 1'b1;
      op(3'b000, 32'd2, 32'd3, 5'd11, 1'b1);
      tick();
      reset = 1'b0;
      #1;
      check("abort_busy", {31'd0, BusyE}, 32'd0);
      check("abort_regwrite", {31'd0, RegWriteM}, 32'd0);
      tick();
      check("abort_add_result", ALUResultM, 32'd5);
      check("abort_add_regwrite", {31'd0, RegWriteM}, 32'd1);
    end
`else
    op(3'b100, 32'd6, 32'd7, 5'd12, 1'b1);
    #1 check("nomul_busy", {31'd0, BusyE}, 32'd0);
    tick();
    check("nomul_result", ALUResultM, 32'd0);
    check("nomul_regwrite", {31'd0, RegWriteM}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
